seven_segment_display_arbiter: RTL and testbench
================================================

// Module: seven_segment_display_arbiter
// PURPOSE
//  Shares the single 4-digit seven-segment display between NUM_REQ independent sources
//  (counter, stopwatch, status code, ...) using req/grant round-robin with a minimum dwell.
//  Drives HEX_display_digits and blank_mask into seven_segment_LED_display_controller.
//  One owner at a time; rotation between live requesters every DWELL_CYCLES.
// PARAMETERS
//  NUM_REQ       3            number of requesters (2..8)
//  DWELL_CYCLES  100_000_000  min cycles an owner holds the display (1 s @ 100 MHz); >=2
//  ID_W          $clog2(NUM_REQ)  width of owner_id (derived, not overridden)
// PORTS
//  clk_100_Mhz         in   1             system clock, all logic on rising edge
//  reset               in   1             asynchronous, active-low reset
//  req                 in   NUM_REQ       per-source request, level-sensitive
//  req_digits          in   NUM_REQ*16    packed 4-nibble value per source; source i at [16*i+:16]
//  grant               out  NUM_REQ       one-hot owner; all-zero when idle
//  owner_id            out  ID_W          index of current owner; 0 when idle
//  display_valid       out  1             1 while a source owns the display
//  HEX_display_digits  out  16            registered digits of owner; [3:0]=ones .. [15:12]=thousands
//  blank_mask          out  4             bit k=1 -> controller blanks digit k (leading-zero)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, grant=0, owner_id=0, display_valid=0,
//   HEX_display_digits=16'h0000, blank_mask=4'b1110, dwell_cnt=0, rr_ptr=0 (source 0 first).
//  FSM states: IDLE, OWNED.
//  IDLE: if any req, pick winner = first set bit scanning rr_ptr, rr_ptr+1, .. mod NUM_REQ;
//   next edge: state=OWNED, grant/owner_id=winner, display_valid=1, dwell_cnt=0,
//   HEX_display_digits=req_digits[winner]. Latency req->grant = 1 cycle.
//  OWNED, each edge: HEX_display_digits <= req_digits[owner] (live update, 1-cycle latency);
//   dwell_cnt increments, saturating at DWELL_CYCLES-1.
//  Owner drops req (any time, dwell irrelevant): re-arbitrate that edge using scan
//   from owner+1; winner found -> new owner next cycle, dwell_cnt=0; none -> IDLE,
//   grant=0, display_valid=0, HEX/blank_mask hold last values.
//  Dwell expired (dwell_cnt==DWELL_CYCLES-1) and owner still requesting: scan from owner+1
//   excluding owner; other requester found -> hand over next cycle, dwell_cnt=0;
//   none -> keep owner, dwell_cnt restarts at 0.
//  Before expiry, requests from non-owners are ignored (no preemption, no priority).
//  rr_ptr <= owner+1 mod NUM_REQ on every grant change, so a continuously requesting source
//   is served within (NUM_REQ-1)*DWELL_CYCLES+1 cycles (no starvation).
//  Handover is glitch-free: grant changes one-hot to one-hot in a single edge, never all-zero.
//  Nibbles >9 pass through unchanged (controller decodes hex).
//  blank_mask, registered with HEX: bit0 always 0; bit k (k=1..3)=1 iff nibbles k..3 all zero.
//   e.g. 16'h0042 -> 4'b1100; 16'h0000 -> 4'b1110; 16'h1000 -> 4'b0000.
//  Simultaneous owner-drop and expiry: treated as owner drop.
//  Reset asserted mid-OWNED: outputs return to reset values immediately (async).
//  req bits for indices >=NUM_REQ do not exist; no X may reach outputs when req=0.
// STRUCTURE
//  display_pkg: typedef logic [3:0] bcd_digit_t; typedef bcd_digit_t [3:0] hex_display_t;
//   typedef enum logic {IDLE, OWNED} disp_arb_state_t; localparam DEFAULT_DWELL.
//  Sub-module rr_priority_picker (combinational): inputs req mask, start index,
//   exclude mask -> found flag + winner index. Arbiter holds FSM, counter, data/blank regs.
// TESTING (bench overrides DWELL_CYCLES=8, NUM_REQ=3)
//  1 Reset: reset=0 with req=3'b111 -> grant=0, HEX=0000, blank_mask=1110; release ->
//    grant=001 one cycle later, HEX=req_digits[0].
//  2 Rotation: req=111 held, digits 1234/0056/0000 -> grant 001,010,100,001 each 8 cycles;
//    blank_mask 0000,1100,1110 per owner.
//  3 Sole requester: req=010 only -> grant stays 010 across multiple dwell expiries, no gaps.
//  4 Early release: owner 0 drops req at dwell_cnt=3 with req[2]=1 -> grant=100 next cycle;
//    all req drop -> IDLE, display_valid=0, HEX holds last value.
//  5 Live update: owner changes digits 0009->0010 -> HEX follows 1 cycle later,
//    blank_mask 1110->1100.
//  6 Async reset mid-OWNED (between clock edges): outputs reset immediately; after
//    release, first grant goes to source 0 (rr_ptr reset).

Source files
------------

// File: rtl/seven_segment_display_arbiter_pkg.sv
// Shared display types, arbiter state encoding and leading-zero blanking helper.
// Pure declarations; no logic, no latency, no flow control.
package display_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [3:0] hex_display_t;

    typedef enum logic {IDLE, OWNED} disp_arb_state_t;

    localparam int DEFAULT_DWELL = 100_000_000;

    // Ones digit is never blanked so a zero value still shows "0".
    function automatic logic [3:0] blank_of(hex_display_t d);
        logic [3:0] b;
        b[0] = 1'b0;
        b[3] = (d[3] == bcd_digit_t'(0));
        b[2] = b[3] && (d[2] == bcd_digit_t'(0));
        b[1] = b[2] && (d[1] == bcd_digit_t'(0));
        return b;
    endfunction

endpackage

// File: rtl/seven_segment_display_arbiter_if.sv
// Request/grant and display bus between display sources and the arbiter.
// Sources drive req/req_digits (master); the arbiter drives grant and display outputs (slave).
interface seven_segment_display_arbiter_if #(
    parameter int NUM_REQ = 3
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*16-1:0] req_digits;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       owner_id;
    logic                  display_valid;
    logic [15:0]           HEX_display_digits;
    logic [3:0]            blank_mask;

    modport master (
        output req, req_digits,
        input  grant, owner_id, display_valid, HEX_display_digits, blank_mask
    );

    modport slave (
        input  req, req_digits,
        output grant, owner_id, display_valid, HEX_display_digits, blank_mask
    );

endinterface

// File: rtl/seven_segment_display_arbiter_picker.sv
// Combinational round-robin picker: first unexcluded request scanning from start, wrapping.
// Zero latency; no flow control.
module rr_priority_picker #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    input  logic [NUM_REQ-1:0] exclude,
    output logic               found,
    output logic [ID_W-1:0]    winner
);

    logic [NUM_REQ-1:0]   cand;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;

    always_comb begin
        cand   = req & ~exclude;
        dbl    = {cand, cand};
        rot    = NUM_REQ'(dbl >> start);
        found  = 1'b0;
        winner = '0;
        // Walk from the far end so the closest offset to start is written last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found  = 1'b1;
                winner = ID_W'((int'(start) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/seven_segment_display_arbiter.sv
// Round-robin owner of the shared 4-digit display with minimum dwell; req->grant 1 cycle,
// digits follow owner with 1-cycle latency. Non-owners simply wait; no backpressure upstream.
module seven_segment_display_arbiter
    import display_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int DWELL_CYCLES = DEFAULT_DWELL
) (
    input logic                          clk_100_Mhz,
    input logic                          reset,
    seven_segment_display_arbiter_if.slave bus
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    disp_arb_state_t    state_q, state_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    hex_display_t       hex_q, hex_d;
    logic [3:0]         blank_q, blank_d;

    logic               owner_req;
    logic               expired;
    logic [ID_W-1:0]    owner_next;
    logic [ID_W-1:0]    pick_start;
    logic [NUM_REQ-1:0] pick_excl;
    logic               pick_found;
    logic [ID_W-1:0]    pick_winner;

    assign owner_req  = |(bus.req & grant_q);
    assign expired    = (cnt_q == DWELL_LAST);
    assign owner_next = ID_W'((int'(owner_q) + 1) % NUM_REQ);
    // Idle scans from the saved pointer; while owned, scan past the owner and never re-pick it.
    assign pick_start = (state_q == IDLE) ? rr_q : owner_next;
    assign pick_excl  = (state_q == IDLE) ? '0 : grant_q;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req     (bus.req),
        .start   (pick_start),
        .exclude (pick_excl),
        .found   (pick_found),
        .winner  (pick_winner)
    );

    function automatic hex_display_t digits_of(logic [NUM_REQ*16-1:0] all, logic [ID_W-1:0] idx);
        return hex_display_t'(all[16*int'(idx) +: 16]);
    endfunction

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        hex_d   = hex_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = OWNED;
                    owner_d = pick_winner;
                    rr_d    = ID_W'((int'(pick_winner) + 1) % NUM_REQ);
                    cnt_d   = '0;
                    grant_d = NUM_REQ'(1) << pick_winner;
                    hex_d   = digits_of(bus.req_digits, pick_winner);
                end
            end
            OWNED: begin
                if ((!owner_req || expired) && pick_found) begin
                    owner_d = pick_winner;
                    rr_d    = ID_W'((int'(pick_winner) + 1) % NUM_REQ);
                    cnt_d   = '0;
                    grant_d = NUM_REQ'(1) << pick_winner;
                    hex_d   = digits_of(bus.req_digits, pick_winner);
                end else if (!owner_req) begin
                    // Display keeps its last frame; the controller just sees valid drop.
                    state_d = IDLE;
                    owner_d = '0;
                    grant_d = '0;
                end else begin
                    hex_d = digits_of(bus.req_digits, owner_q);
                    if (expired) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        blank_d = blank_of(hex_d);
    end

    always_ff @(posedge clk_100_Mhz or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            hex_q   <= '0;
            blank_q <= 4'b1110;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            hex_q   <= hex_d;
            blank_q <= blank_d;
        end
    end

    assign bus.grant              = grant_q;
    assign bus.owner_id           = owner_q;
    assign bus.display_valid      = (state_q == OWNED);
    assign bus.HEX_display_digits = hex_q;
    assign bus.blank_mask         = blank_q;

endmodule

// File: tb/tb_seven_segment_display_arbiter.sv
// Bench for the display arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_seven_segment_display_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] dig [N];

    seven_segment_display_arbiter_if #(.NUM_REQ(N)) bus ();

    seven_segment_display_arbiter #(
        .NUM_REQ      (N),
        .DWELL_CYCLES (DW)
    ) dut (
        .clk_100_Mhz (clk),
        .reset       (rst_n),
        .bus         (bus)
    );

    assign bus.req_digits = {dig[2], dig[1], dig[0]};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the display, how long it has held it, and where the
    // next idle search begins.
    bit          m_valid;
    int          m_owner;
    int          m_age;
    int          m_next_start;
    logic [15:0] m_hex;

    function automatic int first_requester(logic [N-1:0] r, int from, int skip);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (from + k) % N;
            if (r[c] && c != skip) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] leading_blank(logic [15:0] v);
        if (v < 16'h0010) return 4'b1110;
        if (v < 16'h0100) return 4'b1100;
        if (v < 16'h1000) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic model_take(input int w);
        m_valid      = 1'b1;
        m_owner      = w;
        m_age        = 0;
        m_next_start = (w + 1) % N;
        m_hex        = dig[w];
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_owner = 0; m_age = 0; m_next_start = 0; m_hex = 16'h0000;
        end else if (!m_valid) begin
            int w;
            w = first_requester(bus.req, m_next_start, -1);
            if (w >= 0) model_take(w);
        end else begin
            int w;
            bit still, due;
            still = bus.req[m_owner];
            due   = (m_age + 1 >= DW);
            w     = first_requester(bus.req, m_owner + 1, m_owner);
            if (!still) begin
                if (w >= 0) model_take(w);
                else begin m_valid = 1'b0; m_owner = 0; end
            end else if (due && w >= 0) begin
                model_take(w);
            end else begin
                m_age = due ? 0 : m_age + 1;
                m_hex = dig[m_owner];
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] eg;
        eg = m_valid ? 3'(1 << m_owner) : 3'b000;
        check("cycle_outputs",
              {6'd0, bus.grant, bus.owner_id, bus.display_valid, bus.HEX_display_digits, bus.blank_mask},
              {6'd0, eg, 2'(m_owner), m_valid, m_hex, leading_blank(m_hex)});
    end

    initial begin
        bus.req = 3'b111;
        dig[0] = 16'h1234; dig[1] = 16'h0056; dig[2] = 16'h0000;
        rst_n = 1'b0;

        // Reset with every source requesting.
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_hex",   32'(bus.HEX_display_digits), 32'h0);
        check("rst_blank", 32'(bus.blank_mask), 32'b1110);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant", 32'(bus.grant), 32'b001);
        check("first_hex",   32'(bus.HEX_display_digits), 32'h1234);

        // Rotation every DW cycles.
        repeat (7) @(negedge clk);
        check("hold_grant0_k8", 32'(bus.grant), 32'b001);
        @(negedge clk);
        check("rot_grant1", 32'(bus.grant), 32'b010);
        check("rot_blank1", 32'(bus.blank_mask), 32'b1100);
        repeat (8) @(negedge clk);
        check("rot_grant2", 32'(bus.grant), 32'b100);
        check("rot_blank2", 32'(bus.blank_mask), 32'b1110);
        repeat (8) @(negedge clk);
        check("rot_grant0", 32'(bus.grant), 32'b001);
        check("rot_blank0", 32'(bus.blank_mask), 32'b0000);

        // Sole requester keeps the display across several expiries.
        bus.req = 3'b010;
        for (int i = 0; i < 3 * DW; i++) begin
            @(negedge clk);
            check("sole_grant", 32'(bus.grant), 32'b010);
        end

        // Early release at dwell 3 hands over to the next live requester.
        bus.req = 3'b000;
        dig[2]  = 16'h0789;
        @(negedge clk);
        check("idle_valid", 32'(bus.display_valid), 32'h0);
        bus.req = 3'b001;
        @(negedge clk);
        check("early_g0", 32'(bus.grant), 32'b001);
        bus.req = 3'b101;
        repeat (3) @(negedge clk);
        bus.req = 3'b100;
        @(negedge clk);
        check("early_g2",   32'(bus.grant), 32'b100);
        check("early_hex2", 32'(bus.HEX_display_digits), 32'h0789);
        bus.req = 3'b000;
        @(negedge clk);
        check("drop_valid", 32'(bus.display_valid), 32'h0);
        check("drop_grant", 32'(bus.grant), 32'h0);
        check("drop_hex",   32'(bus.HEX_display_digits), 32'h0789);
        check("drop_blank", 32'(bus.blank_mask), 32'b1000);

        // Live digit update while owned.
        dig[0]  = 16'h0009;
        bus.req = 3'b001;
        @(negedge clk);
        check("live_hex_a",   32'(bus.HEX_display_digits), 32'h0009);
        check("live_blank_a", 32'(bus.blank_mask), 32'b1110);
        dig[0] = 16'h0010;
        @(negedge clk);
        check("live_hex_b",   32'(bus.HEX_display_digits), 32'h0010);
        check("live_blank_b", 32'(bus.blank_mask), 32'b1100);

        // Asynchronous reset between edges while source 1 owns the display.
        bus.req = 3'b010;
        repeat (2) @(negedge clk);
        check("pre_areset_grant", 32'(bus.grant), 32'b010);
        #2 rst_n = 1'b0;
        #1;
        check("areset_grant", 32'(bus.grant), 32'h0);
        check("areset_valid", 32'(bus.display_valid), 32'h0);
        check("areset_hex",   32'(bus.HEX_display_digits), 32'h0);
        check("areset_blank", 32'(bus.blank_mask), 32'b1110);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 3'b111;
        @(negedge clk);
        check("post_areset_grant", 32'(bus.grant), 32'b001);

        // Randomized traffic, checked every cycle by the compare process.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            if ($urandom_range(0, 5) == 0) bus.req = 3'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0)
                    dig[i] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
            end
            if ($urandom_range(0, 299) == 0) #2 rst_n = 1'b0;
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
